// File: rtl/vedic_div_pkg.sv
// Shared widths, state encoding and constants for the 6/3 restoring divider.
// Pure declarations: no latency, no flow control.
package vedic_div_pkg;

  localparam int DVD_W = 6;
  localparam int DVS_W = 3;
  localparam int PR_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0]       ITER_LAST = 3'd5;
  localparam logic [DVD_W-1:0] DIV0_QUOT = 6'h3F;

endpackage

// File: rtl/div_trial_sub.sv
// Trial subtract pr_n - divisor as a ripple of full-adder cells, with a borrow-out.
// Combinational, zero latency; no handshake.
module div_trial_sub
  import vedic_div_pkg::*;
(
  input  logic [PR_W-1:0]  pr_n,
  input  logic [DVS_W-1:0] divisor,
  output logic [PR_W-1:0]  diff,
  output logic             borrow
);

  logic [PR_W-1:0] nb;
  logic [PR_W:0]   c;

  // a - b = a + ~b + 1; a missing carry-out means the subtract borrowed
  assign nb   = ~{1'b0, divisor};
  assign c[0] = 1'b1;

  for (genvar i = 0; i < PR_W; i++) begin : g_fa
    assign diff[i]  = pr_n[i] ^ nb[i] ^ c[i];
    assign c[i+1]   = (pr_n[i] & nb[i]) | (c[i] & (pr_n[i] ^ nb[i]));
  end

  assign borrow = ~c[PR_W];

endmodule

// File: rtl/vedic_div6x3.sv
// 6/3 unsigned restoring divider: done 7 clocks after an accepted start (1 for divide-by-zero);
// start is honoured only in IDLE and never queued. VEDIC_DIV_CHECK_EN adds the check_ok self-check output.
module vedic_div6x3
  import vedic_div_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [DVD_W-1:0] quotient,
  output logic [DVS_W-1:0] remainder,
`ifdef VEDIC_DIV_CHECK_EN
  output logic             check_ok,
`endif
  output logic             div_by_zero
);

  state_t           state;
  logic [DVD_W-1:0] dvd;
  logic [PR_W-1:0]  pr;
  logic [2:0]       cnt;
  logic [DVS_W-1:0] dvs;

  logic [PR_W-1:0]  pr_n;
  logic [PR_W-1:0]  diff;
  logic             borrow;
  logic [PR_W-1:0]  pr_next;
  logic             unused_pr_msb;

`ifdef VEDIC_DIV_CHECK_EN
  logic [DVD_W-1:0] dvd_cap;
`endif

  // pr never exceeds the divisor, so its top bit is always zero before the shift
  assign pr_n          = {pr[2:0], dvd[DVD_W-1]};
  assign pr_next       = borrow ? pr_n : diff;
  assign unused_pr_msb = pr[PR_W-1];

  div_trial_sub u_trial (
    .pr_n    (pr_n),
    .divisor (dvs),
    .diff    (diff),
    .borrow  (borrow)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      dvd         <= '0;
      pr          <= '0;
      cnt         <= '0;
      dvs         <= '0;
`ifdef VEDIC_DIV_CHECK_EN
      dvd_cap     <= '0;
      check_ok    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            dvs <= divisor;
`ifdef VEDIC_DIV_CHECK_EN
            dvd_cap <= dividend;
`endif
            if (divisor != '0) begin
              dvd         <= dividend;
              pr          <= '0;
              cnt         <= '0;
              div_by_zero <= 1'b0;
              busy        <= 1'b1;
              state       <= CALC;
            end else begin
              quotient    <= DIV0_QUOT;
              remainder   <= '0;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state       <= DONE;
            end
          end
        end
        CALC: begin
          dvd      <= {dvd[DVD_W-2:0], 1'b0};
          pr       <= pr_next;
          quotient <= {quotient[DVD_W-2:0], ~borrow};
          cnt      <= cnt + 3'd1;
          if (cnt == ITER_LAST) begin
            busy      <= 1'b0;
            done      <= 1'b1;
            remainder <= pr_next[DVS_W-1:0];
            state     <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
`ifdef VEDIC_DIV_CHECK_EN
          check_ok <= ((10'(quotient) * 10'(dvs) + 10'(remainder)) == 10'(dvd_cap))
                      || div_by_zero;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vedic_div6x3.sv
// Directed-vector bench for vedic_div6x3: table of divisions, handshake corner cases, full sweep.
module tb_vedic_div6x3;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [5:0] dividend;
  logic [2:0] divisor;
  logic       busy;
  logic       done;
  logic [5:0] quotient;
  logic [2:0] remainder;
  logic       div_by_zero;
`ifdef VEDIC_DIV_CHECK_EN
  logic       check_ok;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  vedic_div6x3 dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
`ifdef VEDIC_DIV_CHECK_EN
    .check_ok    (check_ok),
`endif
    .div_by_zero (div_by_zero)
  );

  typedef struct {
    logic [5:0] a;
    logic [2:0] b;
    logic [5:0] q;
    logic [2:0] r;
    logic       z;
    int         lat;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Pulse start for one cycle, scramble the inputs afterwards, wait (bounded) for done.
  task automatic run_div(input logic [5:0] a, input logic [2:0] b,
                         output int lat, output int busy_cnt);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    lat = -1; busy_cnt = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      start = 1'b0; dividend = 6'h2A; divisor = 3'd2;
      if (busy) busy_cnt++;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[11];
    int   lat, bcnt, done_k, done_cnt;

    vecs[0]  = '{6'd45, 3'd6, 6'd7,  3'd3, 1'b0, 7};
    vecs[1]  = '{6'd63, 3'd7, 6'd9,  3'd0, 1'b0, 7};
    vecs[2]  = '{6'd49, 3'd7, 6'd7,  3'd0, 1'b0, 7};
    vecs[3]  = '{6'd5,  3'd7, 6'd0,  3'd5, 1'b0, 7};
    vecs[4]  = '{6'd0,  3'd1, 6'd0,  3'd0, 1'b0, 7};
    vecs[5]  = '{6'd20, 3'd0, 6'h3F, 3'd0, 1'b1, 1};
    vecs[6]  = '{6'd63, 3'd1, 6'd63, 3'd0, 1'b0, 7};
    vecs[7]  = '{6'd62, 3'd4, 6'd15, 3'd2, 1'b0, 7};
    vecs[8]  = '{6'd7,  3'd3, 6'd2,  3'd1, 1'b0, 7};
    vecs[9]  = '{6'd60, 3'd5, 6'd12, 3'd0, 1'b0, 7};
    vecs[10] = '{6'd38, 3'd7, 6'd5,  3'd3, 1'b0, 7};

    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_quot", int'(quotient), 0);
    check("rst_rem",  int'(remainder), 0);
    check("rst_dbz",  int'(div_by_zero), 0);
`ifdef VEDIC_DIV_CHECK_EN
    check("rst_chk",  int'(check_ok), 0);
`endif
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_div(vecs[i].a, vecs[i].b, lat, bcnt);
      check($sformatf("v%0d_lat", i),  lat, vecs[i].lat);
      check($sformatf("v%0d_busy", i), bcnt, (vecs[i].z ? 0 : 6));
      check($sformatf("v%0d_quot", i), int'(quotient), int'(vecs[i].q));
      check($sformatf("v%0d_rem", i),  int'(remainder), int'(vecs[i].r));
      check($sformatf("v%0d_dbz", i),  int'(div_by_zero), int'(vecs[i].z));
      @(negedge clk);
      check($sformatf("v%0d_pulse", i), int'(done), 0);
      check($sformatf("v%0d_hold", i),  int'(quotient), int'(vecs[i].q));
`ifdef VEDIC_DIV_CHECK_EN
      check($sformatf("v%0d_chk", i), int'(check_ok), 1);
`endif
    end

    // start re-pulsed mid-calculation and during DONE with different operands: both ignored
    @(negedge clk);
    start = 1'b1; dividend = 6'd45; divisor = 3'd6;
    done_k = -1; done_cnt = 0; bcnt = 0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (done) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
      end
      start = (k == 2 || k == 7);
      if (start) begin
        dividend = 6'd10; divisor = 3'd3;
      end
    end
    start = 1'b0;
    check("ign_lat",   done_k, 7);
    check("ign_ndone", done_cnt, 1);
    check("ign_busy",  bcnt, 6);
    check("ign_quot",  int'(quotient), 7);
    check("ign_rem",   int'(remainder), 3);

    // reset in the 4th CALC cycle aborts; quotient was 7 so partial shifts make it non-zero
    @(negedge clk);
    start = 1'b1; dividend = 6'd45; divisor = 3'd6;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("pre_rst_busy", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_quot", int'(quotient), 0);
    check("abort_rem",  int'(remainder), 0);
    check("abort_dbz",  int'(div_by_zero), 0);
    done_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done || busy) done_cnt++;
    end
    check("abort_quiet", done_cnt, 0);
    run_div(6'd45, 3'd6, lat, bcnt);
    check("after_rst_lat",  lat, 7);
    check("after_rst_quot", int'(quotient), 7);
    check("after_rst_rem",  int'(remainder), 3);

    // full operand sweep against integer division
    for (int a = 0; a < 64; a++) begin
      for (int b = 0; b < 8; b++) begin
        run_div(6'(a), 3'(b), lat, bcnt);
        check($sformatf("sw_%0d_%0d_quot", a, b), int'(quotient), (b == 0) ? 63 : a / b);
        check($sformatf("sw_%0d_%0d_rem", a, b),  int'(remainder), (b == 0) ? 0 : a % b);
        check($sformatf("sw_%0d_%0d_dbz", a, b),  int'(div_by_zero), (b == 0) ? 1 : 0);
        @(negedge clk);
`ifdef VEDIC_DIV_CHECK_EN
        check($sformatf("sw_%0d_%0d_chk", a, b), int'(check_ok), 1);
`endif
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
